// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//
// Game score keeper that sits after the answer checker. It takes one-cycle
// correct/wrong pulses and keeps:
//   - a saturating score (no wrap-around at 2**WIDTH-1),
//   - a streak counter that saturates at COMBO_LEN and opens a combo mode
//     in which every correct answer earns COMBO_BONUS points,
//   - a win flag that latches once the score reaches TARGET,
//   - a high-score register that survives new_game and is cleared only by reset.
//
// Parameters:
//   WIDTH        score / high-score width in bits (2..16)
//   TARGET       win threshold, 1 <= TARGET <= 2**WIDTH-1
//   COMBO_LEN    consecutive correct answers needed to enter combo (1..15)
//   COMBO_BONUS  points per correct answer while in combo (1..2**WIDTH-1)
//
// Build option:
//   PENALTY_EN   when defined, a wrong answer also takes 1 point off the
//                score (floored at 0). The high score is never reduced.
//                The port list is identical in both builds.
//
// Ports:
//   clk           in   1      system clock, rising edge
//   reset         in   1      synchronous active-high, clears everything
//   new_game      in   1      synchronous clear of score/streak/FSM/win
//   is_correct    in   1      one-cycle pulse, correct answer
//   is_wrong      in   1      one-cycle pulse, wrong answer
//   score         out  WIDTH  current score (registered)
//   high_score    out  WIDTH  best score since reset (registered)
//   streak        out  4      consecutive-correct count (registered)
//   combo_active  out  1      FSM is in COMBO (registered)
//   win           out  1      FSM is in DONE (registered)
// -----------------------------------------------------------------------------
module score_tracker #(
    parameter int WIDTH       = 8,
    parameter int TARGET      = 20,
    parameter int COMBO_LEN   = 3,
    parameter int COMBO_BONUS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             is_correct,
    input  logic             is_wrong,
    output logic [WIDTH-1:0] score,
    output logic [WIDTH-1:0] high_score,
    output logic [3:0]       streak,
    output logic             combo_active,
    output logic             win
);

    // -------------------------------------------------------------------------
    // Constants sized to the datapath
    // -------------------------------------------------------------------------
    localparam logic [WIDTH:0]   MAX_SCORE_W = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_W       = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   BONUS_W     = (WIDTH+1)'(COMBO_BONUS);
    localparam logic [WIDTH-1:0] TARGET_W    = WIDTH'(TARGET);
    localparam logic [3:0]       COMBO_LEN_W = 4'(COMBO_LEN);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_COMBO = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_score;
    logic [WIDTH-1:0] w_score_next;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] w_high_next;
    logic [3:0]       r_streak;
    logic [3:0]       w_streak_next;
    logic             r_combo;
    logic             r_win;

    // Decoded answer events: both pulses together cancel out.
    logic w_hit;
    logic w_miss;

    assign w_hit  = is_correct & ~is_wrong;
    assign w_miss = is_wrong & ~is_correct;

    // -------------------------------------------------------------------------
    // Saturating adders. Sums are formed one bit wider than the score so the
    // carry tells us when to clamp at the all-ones value.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   w_sum_one;
    logic [WIDTH:0]   w_sum_bonus;
    logic [WIDTH-1:0] w_score_plus_one;
    logic [WIDTH-1:0] w_score_plus_bonus;
    logic [3:0]       w_streak_inc;

    assign w_sum_one   = {1'b0, r_score} + ONE_W;
    assign w_sum_bonus = {1'b0, r_score} + BONUS_W;

    assign w_score_plus_one   = (w_sum_one   > MAX_SCORE_W) ? MAX_SCORE_W[WIDTH-1:0]
                                                            : w_sum_one[WIDTH-1:0];
    assign w_score_plus_bonus = (w_sum_bonus > MAX_SCORE_W) ? MAX_SCORE_W[WIDTH-1:0]
                                                            : w_sum_bonus[WIDTH-1:0];

    // In PLAY the streak is always below COMBO_LEN (<= 15), so this never wraps.
    assign w_streak_inc = r_streak + 4'd1;

    // Score after a wrong answer.
    logic [WIDTH-1:0] w_score_on_miss;

`ifdef PENALTY_EN
    // Lose one point, but never go below zero.
    assign w_score_on_miss = (r_score == '0) ? '0 : (r_score - WIDTH'(1));
`else
    assign w_score_on_miss = r_score;
`endif

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_score_next  = r_score;
        w_streak_next = r_streak;

        if (new_game) begin
            w_state_next  = ST_PLAY;
            w_score_next  = '0;
            w_streak_next = '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_hit) begin
                        // The answer that completes the streak scores +1;
                        // the bonus only starts with the next correct one.
                        w_score_next  = w_score_plus_one;
                        w_streak_next = w_streak_inc;
                        if (w_streak_inc == COMBO_LEN_W) begin
                            w_state_next = ST_COMBO;
                        end
                    end else if (w_miss) begin
                        w_score_next  = w_score_on_miss;
                        w_streak_next = '0;
                    end
                end

                ST_COMBO: begin
                    if (w_hit) begin
                        w_score_next = w_score_plus_bonus;
                    end else if (w_miss) begin
                        w_score_next  = w_score_on_miss;
                        w_streak_next = '0;
                        w_state_next  = ST_PLAY;
                    end
                end

                ST_DONE: begin
                    // Game over: answers are ignored until reset or new_game.
                end

                default: begin
                    w_state_next  = ST_PLAY;
                    w_score_next  = '0;
                    w_streak_next = '0;
                end
            endcase

            // Win check overrides any PLAY/COMBO transition on the same edge.
            if ((r_state == ST_PLAY || r_state == ST_COMBO) &&
                (w_score_next >= TARGET_W)) begin
                w_state_next = ST_DONE;
            end
        end

        // Tracked on every non-reset edge; a new_game drives score_next to 0
        // so the best score is naturally preserved.
        w_high_next = (w_score_next > r_high) ? w_score_next : r_high;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_PLAY;
            r_score  <= '0;
            r_high   <= '0;
            r_streak <= '0;
            r_combo  <= 1'b0;
            r_win    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_score  <= w_score_next;
            r_high   <= w_high_next;
            r_streak <= w_streak_next;
            // Flags are registered from the next state so the outputs come
            // straight off flops rather than from a state decode.
            r_combo  <= (w_state_next == ST_COMBO);
            r_win    <= (w_state_next == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign score        = r_score;
    assign high_score   = r_high;
    assign streak       = r_streak;
    assign combo_active = r_combo;
    assign win          = r_win;

endmodule

// File: tb/tb_score_tracker.sv
// -----------------------------------------------------------------------------
// tb_score_tracker
//
// Two instances share one stimulus stream: a default build (WIDTH=8,
// TARGET=20) and a narrow build (WIDTH=4, TARGET=15) that exercises the
// saturation/win boundary. A game-level reference model, one per instance,
// predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       is_correct = 1'b0;
    logic       is_wrong = 1'b0;

    logic [7:0] a_score, a_high;
    logic [3:0] a_streak;
    logic       a_combo, a_win;
    logic [3:0] b_score, b_high;
    logic [3:0] b_streak;
    logic       b_combo, b_win;

    always #5 clk = ~clk;

    score_tracker #(.WIDTH(8), .TARGET(20), .COMBO_LEN(3), .COMBO_BONUS(2)) dut_a (
        .clk(clk), .reset(reset), .new_game(new_game),
        .is_correct(is_correct), .is_wrong(is_wrong),
        .score(a_score), .high_score(a_high), .streak(a_streak),
        .combo_active(a_combo), .win(a_win)
    );

    score_tracker #(.WIDTH(4), .TARGET(15), .COMBO_LEN(3), .COMBO_BONUS(2)) dut_b (
        .clk(clk), .reset(reset), .new_game(new_game),
        .is_correct(is_correct), .is_wrong(is_wrong),
        .score(b_score), .high_score(b_high), .streak(b_streak),
        .combo_active(b_combo), .win(b_win)
    );

    // Reference model, index 0 = dut_a, 1 = dut_b
    int m_score [2];
    int m_high  [2];
    int m_streak[2];
    bit m_combo [2];
    bit m_won   [2];
    int p_max   [2] = '{255, 15};
    int p_target[2] = '{20, 15};
    int p_len   [2] = '{3, 3};
    int p_bonus [2] = '{2, 2};

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Game rules applied to one instance for one clock edge.
    task automatic model_edge(input int k, input bit r, input bit ng, input bit c, input bit w);
        if (r) begin
            m_score[k] = 0; m_high[k] = 0; m_streak[k] = 0;
            m_combo[k] = 0; m_won[k] = 0;
            return;
        end
        if (ng) begin
            m_score[k] = 0; m_streak[k] = 0; m_combo[k] = 0; m_won[k] = 0;
        end else if (!m_won[k]) begin
            if (c && !w) begin
                if (m_combo[k]) begin
                    m_score[k] = m_score[k] + p_bonus[k];
                end else begin
                    m_score[k] = m_score[k] + 1;
                    m_streak[k] = m_streak[k] + 1;
                    if (m_streak[k] == p_len[k]) m_combo[k] = 1;
                end
                if (m_score[k] > p_max[k]) m_score[k] = p_max[k];
                if (m_score[k] >= p_target[k]) begin
                    m_won[k] = 1;
                    m_combo[k] = 0;
                end
            end else if (w && !c) begin
                m_streak[k] = 0;
                m_combo[k] = 0;
`ifdef PENALTY_EN
                if (m_score[k] > 0) m_score[k] = m_score[k] - 1;
`endif
            end
        end
        if (m_score[k] > m_high[k]) m_high[k] = m_score[k];
    endtask

    task automatic compare_all(input string tag);
        chk($sformatf("%s a.score", tag),  32'(a_score),  32'(m_score[0]));
        chk($sformatf("%s a.high", tag),   32'(a_high),   32'(m_high[0]));
        chk($sformatf("%s a.streak", tag), 32'(a_streak), 32'(m_streak[0]));
        chk($sformatf("%s a.combo", tag),  32'(a_combo),  32'(m_combo[0]));
        chk($sformatf("%s a.win", tag),    32'(a_win),    32'(m_won[0]));
        chk($sformatf("%s b.score", tag),  32'(b_score),  32'(m_score[1]));
        chk($sformatf("%s b.high", tag),   32'(b_high),   32'(m_high[1]));
        chk($sformatf("%s b.streak", tag), 32'(b_streak), 32'(m_streak[1]));
        chk($sformatf("%s b.combo", tag),  32'(b_combo),  32'(m_combo[1]));
        chk($sformatf("%s b.win", tag),    32'(b_win),    32'(m_won[1]));
    endtask

    // One transaction: drive inputs, take one edge, update model, compare.
    task automatic step(input string tag, input bit r, input bit ng, input bit c, input bit w);
        reset = r; new_game = ng; is_correct = c; is_wrong = w;
        @(posedge clk);
        model_edge(0, r, ng, c, w);
        model_edge(1, r, ng, c, w);
        #1;
        $display("%-12s rst=%0b ng=%0b c=%0b w=%0b | A s=%0d hs=%0d st=%0d cb=%0b win=%0b | B s=%0d hs=%0d st=%0d cb=%0b win=%0b",
                 tag, r, ng, c, w, a_score, a_high, a_streak, a_combo, a_win,
                 b_score, b_high, b_streak, b_combo, b_win);
        compare_all(tag);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_high[k] = 0; m_streak[k] = 0;
            m_combo[k] = 0; m_won[k] = 0;
        end

        // Reset and first combo
        step("reset", 1, 0, 0, 0);
        step("t1.c1", 0, 0, 1, 0);
        step("t1.c2", 0, 0, 1, 0);
        step("t1.c3", 0, 0, 1, 0);
        chk("t1 combo after 3rd", 32'(a_combo), 32'd1);
        step("t1.c4", 0, 0, 1, 0);
        chk("t1 score after 4th", 32'(a_score), 32'd5);

        // Wrong answer in combo, next correct is +1 only
        step("t2.w", 0, 0, 0, 1);
        step("t2.c", 0, 0, 1, 0);

        // Simultaneous pulses in PLAY and in COMBO are ignored
        step("t3.both", 0, 0, 1, 1);
        step("t3.c", 0, 0, 1, 0);
        step("t3.c", 0, 0, 1, 0);
        step("t3.both", 0, 0, 1, 1);
        step("t3.idle", 0, 0, 0, 0);
        // Wrong at score 0 (floor with penalty)
        step("t3.ng", 0, 1, 0, 0);
        step("t3.w0", 0, 0, 0, 1);
        chk("t3 score floor", 32'(a_score), 32'd0);

        // Narrow build driven to the saturation/win boundary
        step("t4.c", 0, 0, 1, 0);
        step("t4.c", 0, 0, 1, 0);
        step("t4.c", 0, 0, 1, 0);
        step("t4.w", 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("t4.c", 0, 0, 1, 0);
        chk("t4 b.win", 32'(b_win), 32'd1);
        chk("t4 b.score", 32'(b_score), 32'd15);
        step("t4.post", 0, 0, 1, 0);
        step("t4.postw", 0, 0, 0, 1);

        // Default build reaches 20, then new_game keeps the high score
        for (int i = 0; i < 4; i++) step("t5.c", 0, 0, 1, 0);
        chk("t5 a.win", 32'(a_win), 32'd1);
        step("t5.ng", 0, 1, 0, 0);
        chk("t5 a.high kept", 32'(a_high), 32'd20);
        step("t5.c", 0, 0, 1, 0);
        step("t5.c", 0, 0, 1, 0);
        step("t5.c", 0, 0, 1, 0);
        step("t5.w", 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("t5.c", 0, 0, 1, 0);

        // Reset mid-combo with a correct pulse in the same cycle
        chk("t6 a.combo pre-reset", 32'(a_combo), 32'd1);
        step("t6.rst+c", 1, 0, 1, 0);
        chk("t6 a.high cleared", 32'(a_high), 32'd0);

        // Randomised play
        for (int i = 0; i < 400; i++) begin
            bit r, ng, c, w;
            r  = ($urandom_range(0, 99) == 0);
            ng = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 99) < 60);
            w  = ($urandom_range(0, 99) < 25);
            step("rand", r, ng, c, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
